// File: rtl/gbt_config_deframer.sv
// Deframes the GBT configuration side-stream into g_pages 32-bit words, committed atomically on a good checksum.
// Optional: define GBT_DEFRAMER_CLEAR_ON_STALE_EN to blank data_ob32 when stale_o rises.
package gbt_config_deframer_pkg;
   typedef struct packed {
      logic clk;
      logic reset;
   } clk_rs_t;
endpackage

module gbt_config_deframer
   import gbt_config_deframer_pkg::*;
#(
   parameter int          g_pages         = 16,
   parameter logic [15:0] g_SyncWord      = 16'hCAFE,
   parameter int          g_TimeoutCycles = 4000000
) (
   input  clk_rs_t                   ClkRs_ix,
   input  logic [15:0]               data_ib16,
   input  logic                      word_valid_i,
   output logic [g_pages-1:0][31:0]  data_ob32,
   output logic                      frame_ok_o,
   output logic                      chksum_err_o,
   output logic                      stale_o,
   output logic [15:0]               err_count_ob16,
   output logic [1:0]                state_ob2
);

   localparam int IDX_W = (g_pages > 1) ? $clog2(g_pages) : 1;
   localparam int TO_W  = $clog2(g_TimeoutCycles + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(g_pages - 1);
   localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(g_TimeoutCycles);

   typedef enum logic [1:0] {S_HUNT, S_HI, S_LO, S_CHK} state_t;

   // Handshake: a word is consumed on any rising edge where word_valid_i is high;
   // there is no backpressure, so every valid word is taken.
   logic clk, rst;
   assign clk = ClkRs_ix.clk;
   assign rst = ClkRs_ix.reset;

   state_t state, state_nxt;
   logic   start_frame, wr_hi, wr_lo, chk_done;

   logic [g_pages-1:0][31:0] shadow;
   logic [IDX_W-1:0]         idx;
   logic [15:0]              sum;
   logic                     commit_q, reject_q;
   logic [TO_W-1:0]          to_cnt, to_nxt;

   assign state_ob2 = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_HUNT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (word_valid_i) begin
         case (state)
            S_HUNT:  if (data_ib16 == g_SyncWord) state_nxt = S_HI;
            S_HI:    state_nxt = S_LO;
            S_LO:    state_nxt = (idx == LAST_IDX) ? S_CHK : S_HI;
            S_CHK:   state_nxt = S_HUNT;
            default: state_nxt = S_HUNT;
         endcase
      end
   end

   always_comb begin
      start_frame = 1'b0;
      wr_hi       = 1'b0;
      wr_lo       = 1'b0;
      chk_done    = 1'b0;
      if (word_valid_i) begin
         case (state)
            S_HUNT:  start_frame = (data_ib16 == g_SyncWord);
            S_HI:    wr_hi       = 1'b1;
            S_LO:    wr_lo       = 1'b1;
            S_CHK:   chk_done    = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow   <= '0;
         idx      <= '0;
         sum      <= '0;
         commit_q <= 1'b0;
         reject_q <= 1'b0;
      end else begin
         commit_q <= chk_done && (data_ib16 == sum);
         reject_q <= chk_done && (data_ib16 != sum);
         if (start_frame) begin
            idx <= '0;
            sum <= '0;
         end
         if (wr_hi) begin
            shadow[idx][31:16] <= data_ib16;
            sum                <= sum + data_ib16;
         end
         if (wr_lo) begin
            shadow[idx][15:0] <= data_ib16;
            sum               <= sum + data_ib16;
            if (idx != LAST_IDX) idx <= idx + 1'b1;
         end
      end
   end

   // A commit restarts the stale timer, which also wins over a simultaneous expiry.
   always_comb begin
      if (commit_q)              to_nxt = '0;
      else if (to_cnt == TO_MAX) to_nxt = to_cnt;
      else                       to_nxt = to_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_ob32      <= '0;
         frame_ok_o     <= 1'b0;
         chksum_err_o   <= 1'b0;
         err_count_ob16 <= '0;
         to_cnt         <= TO_MAX;
         stale_o        <= 1'b1;
      end else begin
         frame_ok_o   <= commit_q;
         chksum_err_o <= reject_q;
         to_cnt       <= to_nxt;
         stale_o      <= (to_nxt == TO_MAX);
         if (reject_q && (err_count_ob16 != 16'hFFFF))
            err_count_ob16 <= err_count_ob16 + 16'd1;
         if (commit_q)
            data_ob32 <= shadow;
`ifdef GBT_DEFRAMER_CLEAR_ON_STALE_EN
         else if ((to_nxt == TO_MAX) && !stale_o)
            data_ob32 <= '0;
`else
`endif
      end
   end

endmodule

// File: tb/tb_gbt_config_deframer.sv
// Randomized bench for gbt_config_deframer checked every cycle against a frame-level reference model.
// Honours GBT_DEFRAMER_CLEAR_ON_STALE_EN in the model when the design is built with it.
module tb_gbt_config_deframer;
   import gbt_config_deframer_pkg::*;

   localparam int          P    = 2;
   localparam int          TO   = 100;
   localparam logic [15:0] SYNC = 16'hCAFE;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   clk_rs_t clk_rs;
   assign clk_rs.clk   = clk;
   assign clk_rs.reset = rst;

   logic [15:0]        din = '0;
   logic               vld = 1'b0;
   logic [P-1:0][31:0] data;
   logic               frame_ok, chksum_err, stale;
   logic [15:0]        err_count;
   logic [1:0]         state_dbg;

   gbt_config_deframer #(.g_pages(P), .g_SyncWord(SYNC), .g_TimeoutCycles(TO)) dut (
      .ClkRs_ix       (clk_rs),
      .data_ib16      (din),
      .word_valid_i   (vld),
      .data_ob32      (data),
      .frame_ok_o     (frame_ok),
      .chksum_err_o   (chksum_err),
      .stale_o        (stale),
      .err_count_ob16 (err_count),
      .state_ob2      (state_dbg)
   );

   // reference model: collects words after SYNC, judges the frame when 2P+1 have arrived
   logic [P-1:0][31:0] m_data, pend_pages;
   logic               m_ok, m_bad, m_stale;
   logic [15:0]        m_err;
   int                 since;
   bit                 in_frame, pend_ok, pend_bad;
   logic [15:0]        words[$];

   always @(posedge clk or posedge rst) begin : model
      logic [15:0] s;
      bit          was_stale;
      if (rst) begin
         m_data = '0; m_ok = 0; m_bad = 0; m_stale = 1; m_err = '0;
         since = TO; in_frame = 0; pend_ok = 0; pend_bad = 0;
         words.delete();
      end else begin
         m_ok  = pend_ok;
         m_bad = pend_bad;
         if (pend_ok) begin
            m_data = pend_pages;
            since  = 0;
         end else if (since < TO) begin
            since = since + 1;
         end
         if (pend_bad && m_err != 16'hFFFF) m_err = m_err + 16'd1;
         was_stale = m_stale;
         m_stale   = (since == TO);
`ifdef GBT_DEFRAMER_CLEAR_ON_STALE_EN
         if (m_stale && !was_stale) m_data = '0;
`endif
         pend_ok = 0; pend_bad = 0;
         if (vld) begin
            if (!in_frame) begin
               if (din == SYNC) begin
                  in_frame = 1;
                  words.delete();
               end
            end else begin
               words.push_back(din);
               if (words.size() == 2*P + 1) begin
                  s = '0;
                  for (int i = 0; i < 2*P; i++) s = s + words[i];
                  for (int i = 0; i < P; i++) pend_pages[i] = {words[2*i], words[2*i+1]};
                  if (s == words[2*P]) pend_ok = 1;
                  else                 pend_bad = 1;
                  in_frame = 0;
               end
            end
         end
      end
   end

   // scoreboard counters and check
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("data",       64'(data),       64'(m_data));
      check("frame_ok",   64'(frame_ok),   64'(m_ok));
      check("chksum_err", 64'(chksum_err), 64'(m_bad));
      check("stale",      64'(stale),      64'(m_stale));
      check("err_count",  64'(err_count),  64'(m_err));
   endtask

   // driver tasks
   task automatic cycle(input logic v, input logic [15:0] w);
      @(negedge clk);
      check_all();
      vld = v;
      din = w;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 16'($urandom));
   endtask

   task automatic send_word(input logic [15:0] w, input int max_gap);
      cycle(1'b1, w);
      repeat ($urandom_range(0, max_gap)) cycle(1'b0, 16'($urandom));
   endtask

   task automatic send_frame(input logic [15:0] d[2*P], input bit corrupt, input int max_gap);
      logic [15:0] s;
      s = '0;
      send_word(SYNC, max_gap);
      for (int i = 0; i < 2*P; i++) begin
         send_word(d[i], max_gap);
         s = s + d[i];
      end
      if (corrupt) s = s + 16'($urandom_range(1, 65535));
      send_word(s, max_gap);
   endtask

   task automatic send_exact(input logic [15:0] d[2*P], input logic [15:0] c, input bit gaps);
      send_word(SYNC, 0);
      if (gaps) cycle(1'b0, SYNC);
      for (int i = 0; i < 2*P; i++) begin
         send_word(d[i], 0);
         if (gaps) cycle(1'b0, 16'($urandom));
      end
      send_word(c, 0);
      if (gaps) cycle(1'b0, 16'($urandom));
   endtask

   logic [15:0] fixed[2*P];
   logic [15:0] rnd[2*P];

   initial begin
      fixed = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      repeat (2) @(negedge clk);
      check_all();
      check("rst_data",  64'(data),      64'h0);
      check("rst_stale", 64'(stale),     64'h1);
      check("rst_err",   64'(err_count), 64'h0);
      rst = 1'b0;

      // contiguous good frame
      send_exact(fixed, 16'hAAAA, 1'b0);
      idle(3);
      check("page0", 64'(data[0]), 64'h11112222);
      check("page1", 64'(data[1]), 64'h33334444);
      check("stale_after_ok", 64'(stale), 64'h0);

      // bad checksum, then gapped good frame
      send_exact(fixed, 16'hAAAB, 1'b0);
      idle(3);
      check("err_one", 64'(err_count), 64'h1);
      fixed = '{16'h5555, 16'h6666, 16'h7777, 16'h8888};
      send_exact(fixed, 16'hCCCC, 1'b0);
      idle(2);
      fixed = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      send_exact(fixed, 16'hAAAA, 1'b1);
      idle(3);
      check("gap_page0", 64'(data[0]), 64'h11112222);

      // timeout, then commit racing the timer expiry
      idle(TO + 5);
      check("timeout_stale", 64'(stale), 64'h1);
      for (int k = TO - 12; k <= TO - 2; k++) begin
         for (int i = 0; i < 2*P; i++) rnd[i] = 16'($urandom);
         send_frame(rnd, 1'b0, 0);
         idle(k);
      end

      // random traffic: junk, sync-valued data, corrupt checksums, gaps
      for (int f = 0; f < 60; f++) begin
         repeat ($urandom_range(0, 3)) send_word(16'($urandom_range(0, 16'hCAFD)), 1);
         for (int i = 0; i < 2*P; i++)
            rnd[i] = ($urandom_range(0, 7) == 0) ? SYNC : 16'($urandom);
         send_frame(rnd, $urandom_range(0, 9) < 3, 2);
      end
      idle(3);

      // saturation of the error counter
      cycle(1'b0, 16'h0);
      force dut.err_count_ob16 = 16'hFFFF;
      m_err = 16'hFFFF;
      cycle(1'b0, 16'h0);
      release dut.err_count_ob16;
      send_exact(fixed, 16'h0001, 1'b0);
      idle(3);
      check("err_sat", 64'(err_count), 64'hFFFF);

      // reset in the middle of a frame, then a normal frame
      send_word(SYNC, 0);
      send_word(16'h1234, 0);
      send_word(16'h5678, 0);
      @(negedge clk);
      check_all();
      rst = 1'b1;
      vld = 1'b0;
      #1;
      check_all();
      check("mid_rst_stale", 64'(stale),     64'h1);
      check("mid_rst_data",  64'(data),      64'h0);
      check("mid_rst_err",   64'(err_count), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      send_exact(fixed, 16'hAAAA, 1'b0);
      idle(3);
      check("post_rst_page1", 64'(data[1]), 64'h33334444);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gbt_config_deframer.md
Name: gbt_config_deframer

Overview:
- Receives the 16-bit configuration side-stream carried in each GBT frame.
- Delimits the stream into frames, verifies a per-frame checksum and commits one 32-bit switches-configuration word per motor page.
- Sits between the GBT receive data register (mem_data_b16 field) and the per-motor extremity-switch decoding and display logic.
- Runs in the GBT frame clock domain. Outputs are updated only by complete, checksum-valid frames.

Parameters:
- g_pages, 16: number of 32-bit pages per frame (one per motor); legal range 1..64.
- g_SyncWord, 16'hCAFE: frame start delimiter.
- g_TimeoutCycles, 4000000: clock cycles without a good frame before stale_o asserts (100 ms at 40 MHz); must be >= 1.

Ports:
- ClkRs_ix.clk  input  1  GBT frame clock.
- ClkRs_ix.reset  input  1  reset, asynchronous, active-high. ClkRs_ix is the codebase's standard clock/reset struct.
- data_ib16  input  16  configuration stream word.
- word_valid_i  input  1  data_ib16 is a valid word this cycle.
- data_ob32  output  g_pages x 32  committed page contents.
- frame_ok_o  output  1  one-cycle pulse when a frame is committed.
- chksum_err_o  output  1  one-cycle pulse when a frame is rejected.
- stale_o  output  1  no good frame for g_TimeoutCycles.
- err_count_ob16  output  16  count of rejected frames, saturating.

Behaviour:
- Reset values:
  - data_ob32 all 0.
  - frame_ok_o, chksum_err_o = 0.
  - stale_o = 1 (nothing received yet).
  - err_count_ob16 = 0.
  - FSM in HUNT; shadow buffer, page index and checksum cleared.
- Frame format, counted in valid words:
  - SYNC word, then for each page p = 0..g_pages-1 a high half and a low half, then one checksum word.
  - Checksum = 16-bit modulo-2^16 sum of all 2*g_pages data words. SYNC is excluded from the sum.
- Words with word_valid_i = 0 are ignored in every state: no state change, no timeout effect on the FSM.
- FSM:
  - HUNT: a valid word == g_SyncWord moves to HI, with page index := 0 and sum := 0. Any other valid word is discarded.
  - HI: the valid word goes to shadow[idx][31:16], sum += word; go to LO.
  - LO: the valid word goes to shadow[idx][15:0], sum += word. If idx == g_pages-1, go to CHK; otherwise idx++ and go to HI.
  - CHK: compare the valid word with sum.
    - Match: copy the whole shadow into data_ob32 at the next edge and pulse frame_ok_o for 1 cycle.
    - Mismatch: data_ob32 unchanged, pulse chksum_err_o, err_count_ob16++ (saturates at 16'hFFFF, never wraps).
    - Either way, return to HUNT.
- A word equal to g_SyncWord received in HI/LO/CHK is treated as ordinary data; no mid-frame resynchronisation.
- Latency: checksum word sampled at edge N → data_ob32 and frame_ok_o valid after edge N+1.
- Commit is atomic: all pages update on the same edge. Consumers never see a mix of two frames.
- Timeout counter:
  - Cleared on every commit; otherwise increments every cycle, saturating at g_TimeoutCycles.
  - stale_o = (counter == g_TimeoutCycles), registered.
  - stale_o deasserts on the same edge as the commit.
- Simultaneous events: a commit in the cycle the counter would reach its limit wins; stale_o stays 0.
- Reset asserted mid-frame: the shadow buffer is discarded and all outputs return to their reset values immediately (asynchronous).

Optional Feature:
- Macro GBT_DEFRAMER_CLEAR_ON_STALE_EN.
- When defined: on the edge where stale_o rises, data_ob32 is cleared to all 0, so the display shows unconfigured motors after link loss. The next good frame restores it.
- When undefined: data_ob32 holds the last committed frame indefinitely; stale_o is a flag only.

Test Plan:
- Reset, g_pages=2 → data_ob32 = {0,0}, stale_o = 1, err_count_ob16 = 0.
- Stream CAFE,1111,2222,3333,4444,AAAA → page0 = 32'h11112222, page1 = 32'h33334444, frame_ok_o pulses 1 cycle after the AAAA word; stale_o = 0.
- Same frame with checksum word AAAB → data_ob32 unchanged, chksum_err_o pulse, err_count_ob16 = 1.
- Valid frame with word_valid_i = 0 gaps after every word → identical result to the contiguous case.
- No frame for g_TimeoutCycles=100 after a good frame → stale_o = 1 at cycle 100. With the macro defined, data_ob32 = 0; without it, data_ob32 is held.
- Force err_count_ob16 to 16'hFFFF, then send a bad frame → count stays FFFF. Assert reset mid-frame → all outputs return to reset values, and the next complete frame commits normally.
